// File: rtl/div6_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state codes,
// default operand width and the iteration-counter width rule.
package div_pkg;

  localparam int DEF_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div6_seq_if.sv
// Start/done handshake and operand/result bus between the divider and its requester.
interface div6_seq_if #(
  parameter int WIDTH = div_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div6_seq_sub_prefix.sv
// N-bit prefix subtractor a - b: adds ~b with carry-in 1 through a Brent-Kung
// generate/propagate tree; borrow is the inverted carry-out.
module sub_prefix #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  localparam int LV = $clog2(N);

  logic [N-1:0] prop;

  always_comb begin
    logic [N-1:0] gc, pc, gn, pn;
    gc   = a & ~b;
    pc   = a ^ ~b;
    prop = pc;
    // Carry-in of 1 folded into bit 0 so every prefix G is a carry.
    gc[0] = gc[0] | pc[0];

    for (int l = 0; l < LV; l++) begin
      gn = gc;
      pn = pc;
      for (int i = 0; i < N; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          gn[i] = gc[i] | (pc[i] & gc[i - (1 << l)]);
          pn[i] = pc[i] & pc[i - (1 << l)];
        end
      end
      gc = gn;
      pc = pn;
    end

    for (int l = LV - 1; l >= 0; l--) begin
      gn = gc;
      pn = pc;
      for (int i = 0; i < N; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (2 << l))) begin
          gn[i] = gc[i] | (pc[i] & gc[i - (1 << l)]);
          pn[i] = pc[i] & pc[i - (1 << l)];
        end
      end
      gc = gn;
      pc = pn;
    end

    diff   = prop ^ {gc[N-2:0], 1'b1};
    borrow = ~gc[N-1];
  end
endmodule

// File: rtl/div6_seq.sv
// Sequential unsigned restoring divider: one prefix-subtractor trial per cycle,
// start/done handshake, results held until the next accepted start.
module div6_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  div6_seq_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial, diff, r_run;
  logic             borrow, q_bit;
  logic [WIDTH-1:0] a_run;
  // Partial remainder stays below the divisor, so its top bit is never consumed.
  logic             unused_r_msb;

  assign trial        = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign q_bit        = ~borrow;
  assign r_run        = borrow ? trial : diff;
  assign a_run        = {a_q[WIDTH-2:0], q_bit};
  assign unused_r_msb = r_q[WIDTH];

  sub_prefix #(.N(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, d_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.dividend;
          d_d   = bus.divisor;
          r_d   = '0;
          cnt_d = CNT_W'(WIDTH - 1);
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        a_d   = a_run;
        r_d   = r_run;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          quot_d  = a_run;
          rem_d   = r_run[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div6_seq.sv
// Bench for div6_seq: timeline-based reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_div6_seq;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst;

  div6_seq_if #(.WIDTH(W)) bus ();
  div6_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start at edge e yields done at e (zero divisor) or e+W,
  // busy over e..e+W-1, and the next acceptance no earlier than done+2.
  int edge_n     = 0;
  int acc_edge   = -100;
  int done_edge  = -100;
  int ready_edge = 0;
  logic         m_zero = 1'b0;
  logic [W-1:0] pend_q = '0, pend_r = '0, cur_q = '0, cur_r = '0;
  logic         cur_z  = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int e;
    if (rst) begin
      acc_edge   <= -100;
      done_edge  <= -100;
      ready_edge <= 0;
      m_zero     <= 1'b0;
      cur_q      <= '0;
      cur_r      <= '0;
      cur_z      <= 1'b0;
    end else begin
      e = edge_n + 1;
      edge_n <= e;
      if (e == done_edge) begin
        cur_q <= pend_q;
        cur_r <= pend_r;
        cur_z <= 1'b0;
      end
      if (e >= ready_edge && bus.start === 1'b1) begin
        acc_edge <= e;
        if (bus.divisor == 0) begin
          m_zero     <= 1'b1;
          cur_q      <= '1;
          cur_r      <= bus.dividend;
          cur_z      <= 1'b1;
          done_edge  <= e;
          ready_edge <= e + 2;
        end else begin
          m_zero     <= 1'b0;
          pend_q     <= bus.dividend / bus.divisor;
          pend_r     <= bus.dividend % bus.divisor;
          done_edge  <= e + W;
          ready_edge <= e + W + 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cycle{busy,done,q,r,dbz}",
          {17'b0, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero},
          {17'b0, (!m_zero && edge_n >= acc_edge && edge_n < acc_edge + W),
           (edge_n == done_edge), cur_q, cur_r, cur_z});
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ign_at,
                        output int lat, output int busy_n,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int  t;
    bit  seen;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    t = edge_n;
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    lat = -1; busy_n = 0; q = '0; r = '0; z = 1'b0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = edge_n - t;
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
      end else begin
        if (k == ign_at) begin
          bus.start = 1'b1; bus.dividend = 6'd10; bus.divisor = 6'd2;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ign_at, input int e_lat, input int e_busy,
                          input logic [W-1:0] e_q, input logic [W-1:0] e_r, input logic e_z);
    int lat, bn;
    logic [W-1:0] q, r;
    logic z;
    run_op(a, b, ign_at, lat, bn, q, r, z);
    check({name, " done_offset"}, lat, e_lat);
    check({name, " busy_cycles"}, bn, e_busy);
    check({name, " quotient"}, 32'(q), 32'(e_q));
    check({name, " remainder"}, 32'(r), 32'(e_r));
    check({name, " div_by_zero"}, 32'(z), 32'(e_z));
  endtask

  initial begin
    int idx, cyc;
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {17'b0, bus.busy, bus.done, bus.quotient, bus.remainder,
                            bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    op_check("45/7",  6'd45, 6'd7,  -1, W, 6, 6'd6,  6'd3,  1'b0);
    op_check("63/1",  6'd63, 6'd1,  -1, W, 6, 6'd63, 6'd0,  1'b0);
    op_check("5/9",   6'd5,  6'd9,  -1, W, 6, 6'd0,  6'd5,  1'b0);
    op_check("63/63", 6'd63, 6'd63, -1, W, 6, 6'd1,  6'd0,  1'b0);
    op_check("17/0",  6'd17, 6'd0,  -1, 0, 0, 6'd63, 6'd17, 1'b1);
    op_check("45/7 with ignored start", 6'd45, 6'd7, 2, W, 6, 6'd6, 6'd3, 1'b0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 6'd45; bus.divisor = 6'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy",  32'(bus.busy), 32'd0);
    check("async rst done",  32'(bus.done), 32'd0);
    check("async rst quot",  32'(bus.quotient), 32'd0);
    check("async rst rem",   32'(bus.remainder), 32'd0);
    check("async rst dbz",   32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op_check("20/3 after rst", 6'd20, 6'd3, -1, W, 6, 6'd6, 6'd2, 1'b0);

    // All operand pairs with start held high; advance once the pair is taken.
    idx = 0;
    cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    {bus.dividend, bus.divisor} = 12'(idx);
    while (idx < 4096 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc_edge == edge_n) begin
        idx++;
        if (idx < 4096) {bus.dividend, bus.divisor} = 12'(idx);
        else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("sweep pairs issued", idx, 4096);
    repeat (W + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
